// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Stall/flush controller for an S-stage in-order pipeline. It turns per-stage
// stall requests and redirect requests into per-register hold, bubble and flush
// enables. A redirect whose resolving instruction cannot yet leave its stage is
// parked and applied later. Saturating statistics and a stall watchdog are also
// kept here.
// hold/bubble/flush are combinational, so a redirect with free downstream
// stages takes effect in the same cycle. They never depend on the counters or
// on the watchdog state.
module pipe_hazard_ctrl #(
    parameter int S          = 5,
    parameter int SW         = $clog2(S),
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             rdy_in,
    input  logic [S-1:0]     stall_req,
    input  logic             flush_req,
    input  logic [SW-1:0]    flush_stage,
    output logic [S-1:0]     hold,
    output logic [S-1:0]     bubble,
    output logic [S-1:0]     flush,
    output logic             flush_pending,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count,
    output logic             deadlock
);

    localparam int              WD_W       = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT_V = WD_W'(WDOG_LIMIT);
    localparam logic [SW-1:0]   STAGE_LO   = SW'(1);
    localparam logic [SW-1:0]   STAGE_HI   = SW'(S - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    // Base stall view, before any redirect is considered.
    logic [S-1:0]     hold_b_s;
    logic [S-1:0]     bubble_b_s;
    logic             acc_s;

    // Redirect resolution.
    logic             req_valid_s;
    logic             eff_valid_s;
    logic [SW-1:0]    eff_stage_s;
    logic             down_busy_s;
    logic [S-1:0]     flush_mask_s;
    logic             apply_s;

    // Final enables.
    logic [S-1:0]     hold_s;
    logic [S-1:0]     bubble_s;
    logic [S-1:0]     flush_s;

    // State.
    logic             pend_r;
    logic [SW-1:0]    pend_stage_r;
    logic [CNT_W-1:0] stall_cycles_r;
    logic [CNT_W-1:0] flush_count_r;
    logic [WD_W-1:0]  wd_cnt_r;
    logic [WD_W-1:0]  wd_next_s;
    logic             deadlock_r;

    // A stall at stage k freezes every register feeding stages 0..k.
    always_comb begin
        hold_b_s = '0;
        acc_s    = 1'b0;
        for (int r = S - 1; r >= 0; r--) begin
            acc_s       = acc_s | stall_req[r];
            hold_b_s[r] = acc_s;
        end
    end

    // The first moving register behind a held one receives a NOP.
    always_comb begin
        bubble_b_s = '0;
        for (int r = 1; r < S; r++) begin
            bubble_b_s[r] = hold_b_s[r-1] & ~hold_b_s[r];
        end
    end

    // A redirect from IF or WB, or from beyond WB, is not meaningful and is ignored.
    assign req_valid_s = flush_req & (flush_stage >= STAGE_LO) & (flush_stage <= STAGE_HI);

    // Merge a new request with the parked one; the older (deeper) stage wins.
    always_comb begin
        if (req_valid_s && pend_r) begin
            eff_valid_s = 1'b1;
            eff_stage_s = (flush_stage > pend_stage_r) ? flush_stage : pend_stage_r;
        end else if (req_valid_s) begin
            eff_valid_s = 1'b1;
            eff_stage_s = flush_stage;
        end else if (pend_r) begin
            eff_valid_s = 1'b1;
            eff_stage_s = pend_stage_r;
        end else begin
            eff_valid_s = 1'b0;
            eff_stage_s = '0;
        end
    end

    // Check if the resolving instruction can advance, and build the flush mask 0..e.
    always_comb begin
        down_busy_s  = 1'b0;
        flush_mask_s = '0;
        for (int r = 0; r < S; r++) begin
            down_busy_s     = down_busy_s | (hold_b_s[r] & (r == (int'(eff_stage_s) + 1)));
            flush_mask_s[r] = (r <= int'(eff_stage_s));
        end
    end

    assign apply_s = eff_valid_s & rdy_in & ~rst_in & ~down_busy_s;

    // Final enables: reset and global freeze hold everything; an applied flush
    // overrides hold/bubble on the registers it clears.
    always_comb begin
        if (rst_in || !rdy_in) begin
            hold_s   = '1;
            bubble_s = '0;
            flush_s  = '0;
        end else if (apply_s) begin
            hold_s   = hold_b_s & ~flush_mask_s;
            bubble_s = bubble_b_s & ~flush_mask_s;
            flush_s  = flush_mask_s;
        end else begin
            hold_s   = hold_b_s;
            bubble_s = bubble_b_s;
            flush_s  = '0;
        end
    end

    // Park a redirect that cannot be applied yet; only application or reset releases it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pend_r       <= 1'b0;
            pend_stage_r <= '0;
        end else if (apply_s) begin
            pend_r       <= 1'b0;
            pend_stage_r <= '0;
        end else if (eff_valid_s) begin
            pend_r       <= 1'b1;
            pend_stage_r <= eff_stage_s;
        end else begin
            pend_r       <= pend_r;
            pend_stage_r <= pend_stage_r;
        end
    end

    // Saturating count of cycles where the PC is held while the pipeline is enabled.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            stall_cycles_r <= '0;
        end else if (rdy_in && hold_s[0] && (stall_cycles_r != CNT_MAX)) begin
            stall_cycles_r <= stall_cycles_r + CNT_W'(1);
        end else begin
            stall_cycles_r <= stall_cycles_r;
        end
    end

    // Saturating count of redirects that actually took effect.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            flush_count_r <= '0;
        end else if (apply_s && (flush_count_r != CNT_MAX)) begin
            flush_count_r <= flush_count_r + CNT_W'(1);
        end else begin
            flush_count_r <= flush_count_r;
        end
    end

    assign wd_next_s = (wd_cnt_r == WD_LIMIT_V) ? wd_cnt_r : wd_cnt_r + WD_W'(1);

    // Watchdog: run length of consecutive enabled stall cycles; a long run sets a sticky flag.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wd_cnt_r   <= '0;
            deadlock_r <= 1'b0;
        end else if (rdy_in) begin
            if (hold_s[0]) begin
                wd_cnt_r   <= wd_next_s;
                deadlock_r <= deadlock_r | (wd_next_s == WD_LIMIT_V);
            end else begin
                wd_cnt_r   <= '0;
                deadlock_r <= deadlock_r;
            end
        end else begin
            wd_cnt_r   <= wd_cnt_r;
            deadlock_r <= deadlock_r;
        end
    end

    assign hold          = hold_s;
    assign bubble        = bubble_s;
    assign flush         = flush_s;
    assign flush_pending = pend_r;
    assign stall_cycles  = stall_cycles_r;
    assign flush_count   = flush_count_r;
    assign deadlock      = deadlock_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (S=5, CNT_W=8, WDOG_LIMIT=4).
// A negedge process compares every output with a behavioural model on each
// checked cycle. The model works from the deepest stalled stage and from
// run lengths. Directed sequences pin literal values, and randomized traffic
// plus saturation runs follow.
module tb_pipe_hazard_ctrl;

    localparam int S   = 5;
    localparam int CW  = 8;
    localparam int LIM = 4;

    logic          clk;
    logic          rst_in;
    logic          rdy_in;
    logic [S-1:0]  stall_req;
    logic          flush_req;
    logic [2:0]    flush_stage;
    logic [S-1:0]  hold;
    logic [S-1:0]  bubble;
    logic [S-1:0]  flush;
    logic          flush_pending;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_count;
    logic          deadlock;

    int total = 0;
    int bad   = 0;
    bit checking_en = 1'b0;

    // Model state.
    bit m_pend    = 1'b0;
    int m_pstage  = 0;
    int m_stall   = 0;
    int m_fcnt    = 0;
    int m_run     = 0;
    bit m_dead    = 1'b0;

    // Model scratch values.
    int         m_hi;
    int         m_e;
    bit         m_rv;
    bit         m_ev;
    bit         m_app;
    logic [4:0] m_hb;
    logic [4:0] m_bb;
    logic [4:0] m_mask;
    logic [4:0] e_hold;
    logic [4:0] e_bub;
    logic [4:0] e_fl;

    pipe_hazard_ctrl #(
        .S(S), .SW(3), .CNT_W(CW), .WDOG_LIMIT(LIM)
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .rdy_in(rdy_in),
        .stall_req(stall_req), .flush_req(flush_req), .flush_stage(flush_stage),
        .hold(hold), .bubble(bubble), .flush(flush),
        .flush_pending(flush_pending), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .deadlock(deadlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit rd, input logic [4:0] st, input bit fr, input logic [2:0] fs);
        @(posedge clk);
        #1;
        rst_in      = r;
        rdy_in      = rd;
        stall_req   = st;
        flush_req   = fr;
        flush_stage = fs;
        #2;
    endtask

    // Compare every output with the model, then advance the model across the coming edge.
    always @(negedge clk) begin
        if (checking_en) begin
            m_hi = -1;
            for (int r = 0; r < S; r++) if (stall_req[r]) m_hi = r;
            m_hb = '0;
            m_bb = '0;
            for (int r = 0; r < S; r++) begin
                m_hb[r] = (r <= m_hi);
                m_bb[r] = (m_hi >= 0) && (r == m_hi + 1);
            end
            m_rv = flush_req && (flush_stage >= 3'd1) && (flush_stage <= 3'd3);
            m_ev = m_rv || m_pend;
            if (m_rv && m_pend) m_e = (int'(flush_stage) > m_pstage) ? int'(flush_stage) : m_pstage;
            else if (m_rv)      m_e = int'(flush_stage);
            else                m_e = m_pstage;
            m_app  = !rst_in && rdy_in && m_ev && (m_hi <= m_e);
            m_mask = m_app ? ((5'd1 << (m_e + 1)) - 5'd1) : 5'd0;
            if (rst_in || !rdy_in) begin
                e_hold = 5'b11111; e_bub = 5'b00000; e_fl = 5'b00000;
            end else begin
                e_hold = m_hb & ~m_mask; e_bub = m_bb & ~m_mask; e_fl = m_mask;
            end
            chk("hold", hold, e_hold);
            chk("bubble", bubble, e_bub);
            chk("flush", flush, e_fl);
            chk("flush_pending", flush_pending, m_pend);
            chk("stall_cycles", stall_cycles, m_stall);
            chk("flush_count", flush_count, m_fcnt);
            chk("deadlock", deadlock, m_dead);

            if (rst_in) begin
                m_pend = 0; m_pstage = 0; m_stall = 0; m_fcnt = 0; m_run = 0; m_dead = 0;
            end else begin
                if (m_app) begin
                    m_pend = 0;
                end else if (m_ev) begin
                    m_pend = 1; m_pstage = m_e;
                end
                if (rdy_in) begin
                    if (e_hold[0]) begin
                        if (m_stall < 255) m_stall++;
                        m_run++;
                        if (m_run >= LIM) m_dead = 1;
                    end else begin
                        m_run = 0;
                    end
                end
                if (m_app && m_fcnt < 255) m_fcnt++;
            end
        end
    end

    initial begin
        rst_in = 1'b1; rdy_in = 1'b1; stall_req = '0; flush_req = 1'b0; flush_stage = '0;
        step(1, 1, 5'b00000, 0, 3'd0);
        checking_en = 1'b1;
        step(1, 1, 5'b00100, 1, 3'd2);
        chk("lit_rst_hold", hold, 5'b11111);
        chk("lit_rst_flush", flush, 5'b00000);

        // Plain stall in MEM.
        step(0, 1, 5'b01000, 0, 3'd0);
        chk("lit_stall_hold", hold, 5'b01111);
        chk("lit_stall_bubble", bubble, 5'b10000);
        chk("lit_stall_flush", flush, 5'b00000);
        chk("lit_stall_cnt0", stall_cycles, 8'd0);
        step(0, 1, 5'b01000, 0, 3'd0);
        chk("lit_stall_cnt1", stall_cycles, 8'd1);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_stall_cnt2", stall_cycles, 8'd2);

        // Immediate flush from EX.
        step(0, 1, 5'b00000, 1, 3'd2);
        chk("lit_imm_flush", flush, 5'b00111);
        chk("lit_imm_hold", hold, 5'b00000);
        chk("lit_imm_bubble", bubble, 5'b00000);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_imm_fcnt", flush_count, 8'd1);
        chk("lit_imm_pend", flush_pending, 1'b0);

        // Deferred flush behind a 3-cycle MEM stall.
        step(0, 1, 5'b01000, 1, 3'd2);
        chk("lit_def_flush0", flush, 5'b00000);
        step(0, 1, 5'b01000, 0, 3'd0);
        chk("lit_def_pend", flush_pending, 1'b1);
        step(0, 1, 5'b01000, 0, 3'd0);
        chk("lit_def_flush1", flush, 5'b00000);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_def_apply", flush, 5'b00111);
        chk("lit_def_hold", hold, 5'b00000);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_def_pend_clr", flush_pending, 1'b0);
        chk("lit_def_fcnt", flush_count, 8'd2);

        // Older request supersedes a younger parked one.
        step(0, 1, 5'b10000, 1, 3'd1);
        step(0, 1, 5'b10000, 1, 3'd3);
        chk("lit_merge_flush0", flush, 5'b00000);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_merge_apply", flush, 5'b01111);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_merge_fcnt", flush_count, 8'd3);

        // Invalid redirect stages are ignored.
        step(0, 1, 5'b00000, 1, 3'd4);
        chk("lit_inv_flush", flush, 5'b00000);
        step(0, 1, 5'b00000, 1, 3'd0);
        chk("lit_inv_pend", flush_pending, 1'b0);

        // Watchdog.
        step(0, 1, 5'b10000, 0, 3'd0);
        step(0, 1, 5'b10000, 0, 3'd0);
        step(0, 1, 5'b10000, 0, 3'd0);
        step(0, 1, 5'b10000, 0, 3'd0);
        chk("lit_wd_not_yet", deadlock, 1'b0);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_wd_set", deadlock, 1'b1);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_wd_sticky", deadlock, 1'b1);
        step(1, 1, 5'b00000, 0, 3'd0);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_rst_dead", deadlock, 1'b0);
        chk("lit_rst_scnt", stall_cycles, 8'd0);
        chk("lit_rst_fcnt", flush_count, 8'd0);
        chk("lit_rst_pend", flush_pending, 1'b0);

        // Global freeze with a redirect.
        step(0, 0, 5'b00000, 1, 3'd2);
        chk("lit_frz_hold", hold, 5'b11111);
        chk("lit_frz_flush", flush, 5'b00000);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_frz_pend", flush_pending, 1'b1);
        chk("lit_frz_scnt", stall_cycles, 8'd0);
        chk("lit_frz_apply", flush, 5'b00111);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_frz_fcnt", flush_count, 8'd1);
        chk("lit_frz_pend_clr", flush_pending, 1'b0);

        // A redirect caught by reset is dropped.
        step(0, 1, 5'b10000, 1, 3'd3);
        step(1, 1, 5'b00000, 0, 3'd0);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_rst_drop", flush_pending, 1'b0);
        chk("lit_rst_drop_fl", flush, 5'b00000);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) == 0, ($urandom % 8) != 0,
                 5'($urandom) & 5'($urandom) & 5'($urandom),
                 ($urandom % 3) == 0, 3'($urandom));
        end

        // Saturation of both counters.
        step(1, 1, 5'b00000, 0, 3'd0);
        for (int i = 0; i < 260; i++) step(0, 1, 5'b00001, 0, 3'd0);
        for (int i = 0; i < 260; i++) step(0, 1, 5'b00000, 1, 3'd2);
        step(0, 1, 5'b00000, 0, 3'd0);
        chk("lit_sat_scnt", stall_cycles, 8'hFF);
        chk("lit_sat_fcnt", flush_count, 8'hFF);

        step(0, 1, 5'b00000, 0, 3'd0);
        checking_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
